cbus_rr_arbiter: RTL and testbench
==================================

// Module: cbus_rr_arbiter
// PURPOSE
//   Shares one cache bus (cbus) between NUM_REQ masters (ICache, DCache, ...) with
//   round-robin priority. Grant is held for a whole transaction (through the beat
//   where cresp.last is high), so bursts are never interleaved. Sits between the
//   L1 caches and the cbus-to-AXI bridge.
//   Also counts data beats and flags any burst whose length does not match its len field.
// PARAMETERS
//   NUM_REQ     2   number of cbus masters, >= 2
//   FIRST_PRIO  0   index that has highest priority after reset
// PORTS
//   clk       in   1                     clock
//   resetn    in   1                     async active-low reset
//   ireqs     in   NUM_REQ*cbus_req_t    per-master requests
//   iresps    out  NUM_REQ*cbus_resp_t   per-master responses
//   oreq      out  cbus_req_t            request to the bridge
//   oresp     in   cbus_resp_t           response from the bridge
//   grant     out  $clog2(NUM_REQ)       index of the current owner (valid when busy=1)
//   busy      out  1                     transaction in progress
//   len_err   out  1                     sticky: last beat seen at a wrong beat count
// BEHAVIOUR
//   - One clock domain; resetn is asynchronous and active-low.
//   - Reset (async, resetn=0):
//     - state=IDLE, prio=FIRST_PRIO, grant=0, beat counter=0, len_err=0.
//     - oreq='0 and every iresps[i]='0 immediately, with no clock edge needed.
//   - States:
//     - IDLE: oreq='0 (valid=0); all iresps='0.
//       - If any ireqs[i].valid, pick the first valid index scanning prio, prio+1, ...
//         (mod NUM_REQ).
//       - Registered: next cycle state=BUSY and grant=picked index.
//       - With no valid requester, stay in IDLE.
//     - BUSY: oreq=ireqs[grant]; iresps[grant]=oresp; all other iresps='0.
//       - Beat counter increments on each cycle with oresp.ready=1.
//       - On oresp.ready & oresp.last: state=IDLE, prio=(grant+1) mod NUM_REQ,
//         counter=0.
//       - If counter != oreq.len on that beat, set len_err=1 (sticky until reset).
//   - Latency:
//     - ireqs.valid to oreq.valid is 1 cycle.
//     - Response path (oresp to iresps[grant]) is combinational, no added latency.
//     - After last there is exactly 1 IDLE cycle before the next grant.
//   - Requests that are not granted see ready=0 and last=0; they keep valid
//     asserted and simply wait.
//   - Fairness: with all masters always requesting, grants rotate 0,1,..,N-1,0, ...
//     Bound: each waits at most NUM_REQ-1 transactions.
//   - Owner dropping valid mid-burst is a protocol violation. oreq.valid follows it;
//     the grant is still held until last.
//   - A request arriving in the same cycle as another master's last is arbitrated
//     in the following IDLE cycle, using the updated prio.
//   - Single-beat (len=0) transactions: counter=0 at last gives no error.
//   - busy = (state==BUSY). grant is unchanged while in IDLE.
// TESTING
//   - Reset: resetn=0 mid-burst (counter=5) -> oreq.valid=0, busy=0, iresps all 0
//     at once. After release, first request from m1 (m0 idle) is granted to m1.
//   - Single master: m0 reads len=15 with ready on every cycle.
//     -> oreq.valid 1 cycle after ireqs[0].valid.
//     -> 16 beats forwarded to iresps[0]; len_err=0; then IDLE.
//   - Contention: m0 and m1 both valid at reset, FIRST_PRIO=0.
//     -> grant order m0, m1, m0.
//     -> m1 sees ready=0 throughout m0's 16-beat burst.
//   - Uncached single beat: m1 write len=0, size=MSIZE4 -> one beat, last=1,
//     counter 0, no error, prio then points to m0.
//   - Length mismatch: oreq.len=15 but bridge asserts last on beat 8 -> len_err=1,
//     which stays 1 across later good transactions until reset.
//   - Back-to-back: m1 raises valid in the same cycle m0's last arrives -> 1 IDLE
//     cycle, then grant=1, busy=1.

Source files
------------

// File: rtl/cbus_rr_arbiter_if.sv
// Cache-bus request/response types and the arbiter's port bundle.
// The arbiter takes the slave modport and the surrounding cache/bridge logic takes the master modport.
package cbus_pkg;

    typedef enum logic [1:0] {
        MSIZE1,
        MSIZE2,
        MSIZE4,
        MSIZE8
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        msize_t      size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        logic [3:0]  len;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

endpackage

interface cbus_rr_arbiter_if #(
    parameter int NUM_REQ = 2
);
    import cbus_pkg::*;

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    cbus_req_t         ireqs  [NUM_REQ];
    cbus_resp_t        iresps [NUM_REQ];
    cbus_req_t         oreq;
    cbus_resp_t        oresp;
    logic [GW-1:0]     grant;
    logic              busy;
    logic              len_err;

    modport slave (
        input  ireqs,
        input  oresp,
        output iresps,
        output oreq,
        output grant,
        output busy,
        output len_err
    );

    modport master (
        output ireqs,
        output oresp,
        input  iresps,
        input  oreq,
        input  grant,
        input  busy,
        input  len_err
    );

endinterface

// File: rtl/cbus_rr_arbiter.sv
// Round-robin arbiter sharing one cache bus among NUM_REQ masters; grant is held for a whole
// burst and a sticky flag records any burst whose beat count disagrees with its len field.
module cbus_rr_arbiter
    import cbus_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int FIRST_PRIO = 0
) (
    input  logic                  clk,
    input  logic                  resetn,
    cbus_rr_arbiter_if.slave      bus
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t            state_q;
    logic [GW-1:0]     grant_q;
    logic [GW-1:0]     prio_q;
    logic [7:0]        cnt_q;
    logic              len_err_q;

    logic [NUM_REQ-1:0] reqValid;
    logic [GW-1:0]      pick_d;
    logic               pickValid;
    logic [GW-1:0]      cand;
    logic [GW-1:0]      prio_d;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_valid
        assign reqValid[g] = bus.ireqs[g].valid;
    end

    // First requester found when scanning upward from the current priority pointer.
    always_comb begin
        pick_d    = '0;
        pickValid = 1'b0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = GW'((int'(prio_q) + i) % NUM_REQ);
            if (!pickValid && reqValid[cand]) begin
                pick_d    = cand;
                pickValid = 1'b1;
            end
        end
    end

    assign prio_d = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            prio_q    <= GW'(FIRST_PRIO);
            cnt_q     <= '0;
            len_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pickValid) begin
                        state_q <= BUSY;
                        grant_q <= pick_d;
                    end
                end
                BUSY: begin
                    if (bus.oresp.ready) begin
                        if (bus.oresp.last) begin
                            state_q <= IDLE;
                            prio_q  <= prio_d;
                            cnt_q   <= '0;
                            if (cnt_q != 8'(bus.oreq.len)) begin
                                len_err_q <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
            endcase
        end
    end

    // Bus muxing is combinational off the registered state so reset silences it instantly.
    always_comb begin
        bus.oreq = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.iresps[i] = '0;
            if (state_q == BUSY && grant_q == GW'(i)) begin
                bus.oreq      = bus.ireqs[i];
                bus.iresps[i] = bus.oresp;
            end
        end
    end

    assign bus.grant   = grant_q;
    assign bus.busy    = (state_q == BUSY);
    assign bus.len_err = len_err_q;

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Scenario bench for cbus_rr_arbiter: directed feature tasks followed by a randomized run
// checked against a transaction-level round-robin model.
module tb_cbus_rr_arbiter;
    import cbus_pkg::*;

    localparam int NREQ = 2;

    logic clk = 1'b0;
    logic resetn;

    int assertCount = 0;
    int failCount   = 0;

    int txLen   [NREQ][8];
    int txBeats [NREQ][8];
    int txCount [NREQ];
    int txHead  [NREQ];

    cbus_rr_arbiter_if #(.NUM_REQ(NREQ)) bus ();

    cbus_rr_arbiter #(
        .NUM_REQ   (NREQ),
        .FIRST_PRIO(0)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic cbus_req_t mkReq(logic wr, logic [3:0] len, logic [31:0] addr);
        cbus_req_t r;
        r          = '0;
        r.valid    = 1'b1;
        r.is_write = wr;
        r.size     = MSIZE4;
        r.addr     = addr;
        r.strobe   = 4'hf;
        r.data     = $urandom;
        r.len      = len;
        return r;
    endfunction

    function automatic cbus_resp_t mkResp(logic rdy, logic lst);
        cbus_resp_t r;
        r.ready = rdy;
        r.last  = lst;
        r.data  = $urandom;
        return r;
    endfunction

    task automatic do_reset();
        resetn = 1'b0;
        for (int i = 0; i < NREQ; i++) bus.ireqs[i] = '0;
        bus.oresp = '0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        assertCount++;
        if (bus.busy !== 1'b0) begin failCount++; $display("[TB] FAIL rst_busy: got %0b expected 0", bus.busy); end
        assertCount++;
        if (bus.grant !== 1'b0) begin failCount++; $display("[TB] FAIL rst_grant: got %0h expected 0", bus.grant); end
        assertCount++;
        if (bus.len_err !== 1'b0) begin failCount++; $display("[TB] FAIL rst_len_err: got %0b expected 0", bus.len_err); end
        assertCount++;
        if (bus.oreq !== '0) begin failCount++; $display("[TB] FAIL rst_oreq: got %0h expected 0", bus.oreq); end
        // Start a long burst and pull reset after five accepted beats.
        @(negedge clk);
        bus.ireqs[0] = mkReq(1'b0, 4'd15, 32'h0000_0400);
        @(negedge clk);
        for (int b = 0; b < 5; b++) begin
            bus.oresp = mkResp(1'b1, 1'b0);
            @(negedge clk);
        end
        bus.oresp = mkResp(1'b1, 1'b0);
        #2;
        resetn = 1'b0;
        #1;
        assertCount++;
        if (bus.oreq.valid !== 1'b0) begin failCount++; $display("[TB] FAIL rst_async_oreq: got %0b expected 0", bus.oreq.valid); end
        assertCount++;
        if (bus.busy !== 1'b0) begin failCount++; $display("[TB] FAIL rst_async_busy: got %0b expected 0", bus.busy); end
        assertCount++;
        if (bus.iresps[0] !== '0 || bus.iresps[1] !== '0) begin
            failCount++;
            $display("[TB] FAIL rst_async_iresps: got %0h/%0h expected 0/0", bus.iresps[0], bus.iresps[1]);
        end
        @(negedge clk);
        resetn       = 1'b1;
        bus.oresp    = '0;
        bus.ireqs[0] = '0;
        bus.ireqs[1] = mkReq(1'b0, 4'd0, 32'h0000_0800);
        @(negedge clk);
        #1;
        assertCount++;
        if (bus.busy !== 1'b1 || bus.grant !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL rst_then_m1: got busy=%0b grant=%0h expected busy=1 grant=1", bus.busy, bus.grant);
        end
        bus.oresp = mkResp(1'b1, 1'b1);
        @(negedge clk);
        bus.oresp    = '0;
        bus.ireqs[1] = '0;
    endtask

    task automatic test_single();
        @(negedge clk);
        bus.ireqs[0] = mkReq(1'b0, 4'd15, 32'h0000_1000);
        #1;
        assertCount++;
        if (bus.oreq.valid !== 1'b0) begin failCount++; $display("[TB] FAIL single_lat0: got %0b expected 0", bus.oreq.valid); end
        @(negedge clk);
        #1;
        assertCount++;
        if (bus.oreq.valid !== 1'b1 || bus.grant !== 1'b0 || bus.busy !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL single_lat1: got valid=%0b grant=%0h busy=%0b expected 1/0/1",
                     bus.oreq.valid, bus.grant, bus.busy);
        end
        for (int b = 0; b < 16; b++) begin
            bus.oresp = mkResp(1'b1, b == 15);
            #1;
            assertCount++;
            if (bus.iresps[0] !== bus.oresp || bus.iresps[1] !== '0) begin
                failCount++;
                $display("[TB] FAIL single_fwd: beat %0d got %0h/%0h expected %0h/0",
                         b, bus.iresps[0], bus.iresps[1], bus.oresp);
            end
            @(negedge clk);
        end
        bus.ireqs[0] = '0;
        bus.oresp    = '0;
        #1;
        assertCount++;
        if (bus.busy !== 1'b0 || bus.len_err !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL single_end: got busy=%0b len_err=%0b expected 0/0", bus.busy, bus.len_err);
        end
    endtask

    task automatic test_contention();
        int expOrder [3];
        int owner;
        int beats;
        expOrder = '{0, 1, 0};
        resetn = 1'b0;
        bus.oresp    = '0;
        bus.ireqs[0] = mkReq(1'b0, 4'd15, 32'h0000_2000);
        bus.ireqs[1] = mkReq(1'b0, 4'd3,  32'h0000_3000);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        for (int t = 0; t < 3; t++) begin
            owner = expOrder[t];
            beats = (owner == 0) ? 16 : 4;
            @(negedge clk);
            #1;
            assertCount++;
            if (bus.busy !== 1'b1 || int'(bus.grant) !== owner) begin
                failCount++;
                $display("[TB] FAIL contend_grant: txn %0d got busy=%0b grant=%0h expected 1/%0d",
                         t, bus.busy, bus.grant, owner);
            end
            for (int b = 0; b < beats; b++) begin
                bus.oresp = mkResp(1'b1, b == beats - 1);
                #1;
                assertCount++;
                if (bus.iresps[owner] !== bus.oresp || bus.iresps[1-owner].ready !== 1'b0
                    || bus.iresps[1-owner].last !== 1'b0) begin
                    failCount++;
                    $display("[TB] FAIL contend_fwd: txn %0d beat %0d got %0h/%0h expected %0h/0",
                             t, b, bus.iresps[owner], bus.iresps[1-owner], bus.oresp);
                end
                @(negedge clk);
            end
            bus.oresp = '0;
            if (t == 1) bus.ireqs[1] = '0;
            if (t == 2) bus.ireqs[0] = '0;
            #1;
            assertCount++;
            if (bus.busy !== 1'b0) begin failCount++; $display("[TB] FAIL contend_idle: txn %0d got busy=%0b expected 0", t, bus.busy); end
        end
    endtask

    task automatic test_single_beat();
        @(negedge clk);
        bus.ireqs[1] = mkReq(1'b1, 4'd0, 32'hC000_0010);
        @(negedge clk);
        #1;
        assertCount++;
        if (bus.grant !== 1'b1 || bus.oreq.is_write !== 1'b1 || bus.oreq.size !== MSIZE4) begin
            failCount++;
            $display("[TB] FAIL sbeat_req: got grant=%0h wr=%0b size=%0d expected 1/1/%0d",
                     bus.grant, bus.oreq.is_write, bus.oreq.size, MSIZE4);
        end
        bus.oresp = mkResp(1'b1, 1'b1);
        #1;
        assertCount++;
        if (bus.iresps[1].last !== 1'b1 || bus.iresps[1].ready !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL sbeat_last: got ready=%0b last=%0b expected 1/1", bus.iresps[1].ready, bus.iresps[1].last);
        end
        @(negedge clk);
        bus.oresp    = '0;
        bus.ireqs[0] = mkReq(1'b0, 4'd0, 32'h0000_4000);
        bus.ireqs[1] = mkReq(1'b0, 4'd0, 32'h0000_5000);
        #1;
        assertCount++;
        if (bus.busy !== 1'b0 || bus.len_err !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL sbeat_idle: got busy=%0b len_err=%0b expected 0/0", bus.busy, bus.len_err);
        end
        @(negedge clk);
        #1;
        assertCount++;
        if (bus.grant !== 1'b0) begin failCount++; $display("[TB] FAIL sbeat_prio: got grant=%0h expected 0", bus.grant); end
        bus.oresp = mkResp(1'b1, 1'b1);
        @(negedge clk);
        bus.oresp    = '0;
        bus.ireqs[0] = '0;
        @(negedge clk);
        #1;
        assertCount++;
        if (bus.busy !== 1'b1 || bus.grant !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL sbeat_m1_again: got busy=%0b grant=%0h expected 1/1", bus.busy, bus.grant);
        end
        bus.oresp = mkResp(1'b1, 1'b1);
        @(negedge clk);
        bus.oresp    = '0;
        bus.ireqs[1] = '0;
    endtask

    task automatic test_len_mismatch();
        @(negedge clk);
        bus.ireqs[0] = mkReq(1'b0, 4'd15, 32'h0000_6000);
        @(negedge clk);
        for (int b = 0; b < 8; b++) begin
            bus.oresp = mkResp(1'b1, b == 7);
            #1;
            if (b == 7) begin
                assertCount++;
                if (bus.len_err !== 1'b0) begin failCount++; $display("[TB] FAIL lenerr_before: got %0b expected 0", bus.len_err); end
            end
            @(negedge clk);
        end
        bus.oresp    = '0;
        bus.ireqs[0] = '0;
        #1;
        assertCount++;
        if (bus.len_err !== 1'b1) begin failCount++; $display("[TB] FAIL lenerr_set: got %0b expected 1", bus.len_err); end
        // A well-formed follow-up burst must not clear the sticky flag.
        @(negedge clk);
        bus.ireqs[1] = mkReq(1'b0, 4'd1, 32'h0000_7000);
        @(negedge clk);
        for (int b = 0; b < 2; b++) begin
            bus.oresp = mkResp(1'b1, b == 1);
            @(negedge clk);
        end
        bus.oresp    = '0;
        bus.ireqs[1] = '0;
        #1;
        assertCount++;
        if (bus.len_err !== 1'b1) begin failCount++; $display("[TB] FAIL lenerr_sticky: got %0b expected 1", bus.len_err); end
        do_reset();
        #1;
        assertCount++;
        if (bus.len_err !== 1'b0) begin failCount++; $display("[TB] FAIL lenerr_clear: got %0b expected 0", bus.len_err); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.ireqs[0] = mkReq(1'b0, 4'd3, 32'h0000_8000);
        @(negedge clk);
        #1;
        assertCount++;
        if (bus.busy !== 1'b1 || bus.grant !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL b2b_first: got busy=%0b grant=%0h expected 1/0", bus.busy, bus.grant);
        end
        for (int b = 0; b < 4; b++) begin
            bus.oresp = mkResp(1'b1, b == 3);
            if (b == 3) bus.ireqs[1] = mkReq(1'b0, 4'd0, 32'h0000_9000);
            @(negedge clk);
        end
        bus.oresp    = '0;
        bus.ireqs[0] = mkReq(1'b0, 4'd0, 32'h0000_8100);
        #1;
        assertCount++;
        if (bus.busy !== 1'b0) begin failCount++; $display("[TB] FAIL b2b_idle: got busy=%0b expected 0", bus.busy); end
        @(negedge clk);
        #1;
        assertCount++;
        if (bus.busy !== 1'b1 || bus.grant !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL b2b_grant: got busy=%0b grant=%0h expected 1/1", bus.busy, bus.grant);
        end
        bus.oresp = mkResp(1'b1, 1'b1);
        @(negedge clk);
        bus.oresp    = '0;
        bus.ireqs[0] = '0;
        bus.ireqs[1] = '0;
        @(negedge clk);
    endtask

    function automatic logic [31:0] txAddr(int m, int k);
        return 32'h0001_0000 * 32'(m + 1) + 32'(k * 64);
    endfunction

    task automatic presentHeads();
        for (int m = 0; m < NREQ; m++) begin
            if (txHead[m] < txCount[m]) begin
                bus.ireqs[m] = mkReq(1'(m), 4'(txLen[m][txHead[m]]), txAddr(m, txHead[m]));
            end else begin
                bus.ireqs[m] = '0;
            end
        end
    endtask

    task automatic test_random();
        int   modelPrio;
        logic expErr;
        int   expOwner;
        int   cand;
        int   beats;
        int   b;
        int   cyc;
        int   pending;
        logic rdy;
        do_reset();
        modelPrio = 0;
        expErr    = 1'b0;
        for (int m = 0; m < NREQ; m++) begin
            txCount[m] = $urandom_range(3, 8);
            txHead[m]  = 0;
            for (int k = 0; k < 8; k++) begin
                txLen[m][k]   = $urandom_range(0, 7);
                txBeats[m][k] = txLen[m][k] + 1;
                if ($urandom_range(0, 4) == 0) begin
                    while (txBeats[m][k] == txLen[m][k] + 1) txBeats[m][k] = $urandom_range(1, 16);
                end
            end
        end
        presentHeads();
        #1;
        pending = txCount[0] + txCount[1];
        while (pending > 0) begin
            expOwner = -1;
            for (int k = 0; k < NREQ; k++) begin
                cand = (modelPrio + k) % NREQ;
                if (expOwner < 0 && txHead[cand] < txCount[cand]) expOwner = cand;
            end
            @(negedge clk);
            #1;
            assertCount++;
            if (bus.busy !== 1'b1 || int'(bus.grant) !== expOwner) begin
                failCount++;
                $display("[TB] FAIL rand_grant: got busy=%0b grant=%0h expected 1/%0d", bus.busy, bus.grant, expOwner);
                break;
            end
            assertCount++;
            if (bus.oreq.addr !== txAddr(expOwner, txHead[expOwner])
                || int'(bus.oreq.len) !== txLen[expOwner][txHead[expOwner]]) begin
                failCount++;
                $display("[TB] FAIL rand_oreq: got addr=%0h len=%0d expected %0h/%0d", bus.oreq.addr, bus.oreq.len,
                         txAddr(expOwner, txHead[expOwner]), txLen[expOwner][txHead[expOwner]]);
            end
            beats = txBeats[expOwner][txHead[expOwner]];
            b   = 0;
            cyc = 0;
            while (b < beats && cyc < 200) begin
                rdy       = ($urandom_range(0, 3) != 0);
                bus.oresp = mkResp(rdy, rdy && (b == beats - 1));
                #1;
                assertCount++;
                if (bus.iresps[expOwner] !== bus.oresp || bus.iresps[1-expOwner] !== '0) begin
                    failCount++;
                    $display("[TB] FAIL rand_fwd: got %0h/%0h expected %0h/0",
                             bus.iresps[expOwner], bus.iresps[1-expOwner], bus.oresp);
                end
                if (rdy) b++;
                cyc++;
                @(negedge clk);
            end
            if (b < beats) begin
                failCount++;
                $display("[TB] FAIL rand_timeout: got %0d beats expected %0d", b, beats);
                break;
            end
            if (beats != txLen[expOwner][txHead[expOwner]] + 1) expErr = 1'b1;
            modelPrio = (expOwner + 1) % NREQ;
            txHead[expOwner]++;
            pending--;
            bus.oresp = '0;
            presentHeads();
            #1;
            assertCount++;
            if (bus.busy !== 1'b0 || bus.len_err !== expErr) begin
                failCount++;
                $display("[TB] FAIL rand_idle: got busy=%0b len_err=%0b expected 0/%0b", bus.busy, bus.len_err, expErr);
            end
        end
        for (int i = 0; i < NREQ; i++) bus.ireqs[i] = '0;
        bus.oresp = '0;
    endtask

    initial begin
        do_reset();
        test_reset();
        test_single();
        test_contention();
        test_single_beat();
        test_len_mismatch();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
